udma_l2_port_arbiter: RTL
=========================

// Module: udma_l2_port_arbiter
// PURPOSE
// Parametrised N-to-1 arbiter for the uDMA L2 memory ports. It generalises the fixed read-only/write-only
// port pair to N_PORTS uDMA masters sharing a single TCDM-style L2 port (req/gnt/rvalid).
// It provides round-robin arbitration, holds the request stable while waiting for grant, and tracks
// outstanding transactions so in-order responses are routed back to the issuing master.
// Sits between udma_subsystem L2 masters and the SoC L2 interconnect.
// PARAMETERS
// N_PORTS          2   number of master ports (>=2)
// DATA_WIDTH       32  L2 data width; byte enables are DATA_WIDTH/8 bits
// MAX_OUTSTANDING  4   depth of response-routing FIFO (>=1); caps in-flight transactions
// WRITE_RESP       1   1: writes return rvalid and are tracked; 0: only reads are tracked
// PORTS
// sys_clk_i       in   1                        uDMA core clock
// sys_rst_ni      in   1                        asynchronous active-low reset
// in_req_i        in   N_PORTS                  per-master request
// in_gnt_o        out  N_PORTS                  per-master grant
// in_wen_i        in   N_PORTS                  per-master write enable, active-low (0=write)
// in_addr_i       in   N_PORTS x 32             per-master address
// in_wdata_i      in   N_PORTS x DATA_WIDTH     per-master write data
// in_be_i         in   N_PORTS x DATA_WIDTH/8   per-master byte enables
// in_rvalid_o     out  N_PORTS                  per-master response valid (one-hot or zero)
// in_rdata_o      out  DATA_WIDTH               response data, broadcast to all masters
// l2_req_o        out  1                        L2 request
// l2_gnt_i        in   1                        L2 grant
// l2_wen_o        out  1                        L2 write enable, active-low
// l2_addr_o       out  32                       L2 address
// l2_wdata_o      out  DATA_WIDTH               L2 write data
// l2_be_o         out  DATA_WIDTH/8             L2 byte enables
// l2_rvalid_i     in   1                        L2 response valid
// l2_rdata_i      in   DATA_WIDTH               L2 response data
// outstanding_o   out  $clog2(MAX_OUTSTANDING+1) number of in-flight tracked transactions
// err_o           out  1                        sticky error: rvalid received with nothing outstanding
// BEHAVIOUR
// - Reset values: rr pointer=0, lock=0, FIFO empty, outstanding_o=0, err_o=0.
//   l2_req_o, in_gnt_o and in_rvalid_o are 0 in reset.
// - Handshake: a transaction is accepted when l2_req_o & l2_gnt_i.
//   in_gnt_o[k] = l2_gnt_i & l2_req_o & (sel==k), combinational.
// - Arbitration: when unlocked, sel = the first requesting port at or after the rr pointer
//   (wraps N_PORTS-1 -> 0). After an accepted transaction, pointer = sel+1 mod N_PORTS.
// - Lock: if l2_req_o=1 and l2_gnt_i=0, lock=1 and sel is frozen. While locked, l2_addr/wen/wdata/be
//   are driven from the frozen sel. Lock clears on acceptance. Masters keep req high until granted.
// - Mux: l2_addr/wen/wdata/be = in_*[sel]. Their value is don't-care when l2_req_o=0.
// - Backpressure: l2_req_o = any(in_req_i) & (count < MAX_OUTSTANDING).
//   Full masks new requests even if a pop occurs the same cycle.
//   An untracked write (WRITE_RESP=0) is never blocked by a full FIFO.
// - Tracking: on acceptance of a tracked transaction (read, or write when WRITE_RESP=1), push sel.
//   On l2_rvalid_i with FIFO non-empty, pop. Push and pop in the same cycle leave count unchanged.
// - Response: in_rvalid_o[head]=l2_rvalid_i when FIFO non-empty; in_rdata_o=l2_rdata_i.
//   Zero added latency.
// - Error: l2_rvalid_i while FIFO empty sets err_o (cleared only by reset). No in_rvalid_o asserted.
// - FIFO pointers wrap modulo MAX_OUTSTANDING; count is MAX_OUTSTANDING+1 states wide.
// - Reset mid-operation: FIFO, lock and pointer are discarded immediately (async).
//   Responses still in flight after reset release are counted as errors.
// TESTING
// - Single master: port0 read, gnt same cycle, rvalid +1 -> in_gnt_o=01, in_rvalid_o=01, rdata passed, outstanding 1->0.
// - N_PORTS=4, all req each cycle, gnt=1 -> grant order 0,1,2,3,0,... and each port gets 1 of 4 grants.
// - Port2 req, gnt low 3 cycles while port1 raises req -> addr/sel held on port2, port2 granted first, then port1.
// - MAX_OUTSTANDING=4, 4 reads accepted, no rvalid -> l2_req_o=0 and outstanding_o=4. One rvalid -> next cycle req resumes.
// - Interleaved ports 3,0,3 accepted, 3 rvalids -> in_rvalid_o = 1000, 0001, 1000 in order.
// - rvalid with empty FIFO -> err_o=1 and stays set. Assert reset with 2 outstanding -> outstanding_o=0, err_o=0.

Source files
------------

// File: rtl/udma_l2_port_arbiter.sv
// udma_l2_port_arbiter: N-to-1 round-robin arbiter from uDMA masters onto one
// TCDM-style L2 port (req/gnt/rvalid).
//   in_*        per-master request side (req/gnt/wen/addr/wdata/be, rvalid/rdata back)
//   l2_*        shared L2 port towards the SoC interconnect
//   outstanding_o  number of in-flight tracked transactions
//   err_o       sticky: a response arrived with nothing outstanding
// A request that is not granted freezes the selection until it is accepted.
// Accepted tracked transactions push the issuing port index into a FIFO. In-order
// responses pop the FIFO and are steered to the port at its head.
module udma_l2_port_arbiter #(
  parameter int unsigned N_PORTS         = 2,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned WRITE_RESP      = 1,
  localparam int unsigned BE_W  = DATA_WIDTH / 8,
  localparam int unsigned IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1,
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                 sys_clk_i,
  input  logic                                 sys_rst_ni,
  input  logic [N_PORTS-1:0]                   in_req_i,
  output logic [N_PORTS-1:0]                   in_gnt_o,
  input  logic [N_PORTS-1:0]                   in_wen_i,
  input  logic [N_PORTS-1:0][31:0]             in_addr_i,
  input  logic [N_PORTS-1:0][DATA_WIDTH-1:0]   in_wdata_i,
  input  logic [N_PORTS-1:0][BE_W-1:0]         in_be_i,
  output logic [N_PORTS-1:0]                   in_rvalid_o,
  output logic [DATA_WIDTH-1:0]                in_rdata_o,
  output logic                                 l2_req_o,
  input  logic                                 l2_gnt_i,
  output logic                                 l2_wen_o,
  output logic [31:0]                          l2_addr_o,
  output logic [DATA_WIDTH-1:0]                l2_wdata_o,
  output logic [BE_W-1:0]                      l2_be_o,
  input  logic                                 l2_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                l2_rdata_i,
  output logic [CNT_W-1:0]                     outstanding_o,
  output logic                                 err_o
);

  logic [IDX_W-1:0]                      rr_q, rr_d;
  logic [IDX_W-1:0]                      sel_q, sel_d;
  logic                                  lock_q, lock_d;
  logic [MAX_OUTSTANDING-1:0][IDX_W-1:0] fifo_q, fifo_d;
  logic [PTR_W-1:0]                      wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]                      cnt_q, cnt_d;
  logic                                  err_q, err_d;

  logic [IDX_W-1:0] sel, sel_rr, scan_idx;
  logic             found, sel_tracked, full, accept, push, pop;

  // Round-robin scan from the pointer; a locked request keeps its frozen port.
  always_comb begin
    sel_rr   = rr_q;
    scan_idx = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      scan_idx = IDX_W'((32'(rr_q) + i) % N_PORTS);
      if (!found && in_req_i[scan_idx]) begin
        found  = 1'b1;
        sel_rr = scan_idx;
      end
    end
    sel = lock_q ? sel_q : sel_rr;
  end

  // Handshake, backpressure and response steering.
  always_comb begin
    // Writes (wen=0) only need a FIFO slot when they produce a response.
    sel_tracked = in_wen_i[sel] | (WRITE_RESP != 0);
    full        = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    l2_req_o    = sys_rst_ni & (|in_req_i) & (~full | ~sel_tracked);
    accept      = l2_req_o & l2_gnt_i;
    push        = accept & sel_tracked;
    pop         = l2_rvalid_i & (cnt_q != '0);

    in_gnt_o        = '0;
    in_gnt_o[sel]   = accept;
    l2_wen_o        = in_wen_i[sel];
    l2_addr_o       = in_addr_i[sel];
    l2_wdata_o      = in_wdata_i[sel];
    l2_be_o         = in_be_i[sel];

    in_rvalid_o               = '0;
    in_rvalid_o[fifo_q[rd_q]] = pop;
    in_rdata_o                = l2_rdata_i;
    outstanding_o             = cnt_q;
    err_o                     = err_q;
  end

  // Next-state: pointer, lock, routing FIFO and sticky error.
  always_comb begin
    rr_d   = rr_q;
    sel_d  = sel;
    lock_d = l2_req_o & ~l2_gnt_i;
    fifo_d = fifo_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    err_d  = err_q | (l2_rvalid_i & (cnt_q == '0));

    if (accept) begin
      rr_d = (sel == IDX_W'(N_PORTS - 1)) ? '0 : sel + IDX_W'(1);
    end
    if (push) begin
      fifo_d[wr_q] = sel;
      wr_d = (wr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_d = (rd_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers.
  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      rr_q   <= '0;
      sel_q  <= '0;
      lock_q <= 1'b0;
      fifo_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      rr_q   <= rr_d;
      sel_q  <= sel_d;
      lock_q <= lock_d;
      fifo_q <= fifo_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

endmodule
